uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Downstream consumer of the CPU core's 9-bit console strobe {valid, data[7:0]}. Buffers each strobed byte in a small synchronous FIFO and serialises it onto a real 8N1 TX line at a fixed clocks-per-bit rate. It replaces the testbench-only character printer when the core is built for hardware, so program output becomes a physical serial stream. Status outputs let the bench check back-pressure loss and line activity.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥2.
FIFO_DEPTH, 16, FIFO entries; must be a power of two, ≥2.
FIFO_AW, $clog2(FIFO_DEPTH), derived address width; not overridden.

Ports:
clock  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
uart_in  in  9  [8]=valid strobe, [7:0]=byte; one push per cycle with [8]=1.
tx  out  1  serial line; idles high.
busy  out  1  high when a frame is on the line or the FIFO is non-empty.
fifo_full  out  1  count == FIFO_DEPTH.
overflow  out  1  sticky; set when a push is dropped.
fifo_count  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, fifo_full=0, overflow=0, fifo_count=0. The FSM goes to IDLE, the baud and bit counters clear, and FIFO pointers clear.
- Reset mid-frame: the frame is abandoned and tx=1 on the next cycle. FIFO contents are discarded.
- Push accepted if uart_in[8]=1 and either count<DEPTH or a pop occurs in the same cycle.
- Push when full with no pop: byte dropped, overflow←1. Overflow stays set until reset.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. Count is a separate FIFO_AW+1 bit register.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency: push at edge t, so the byte is visible in the FIFO after t. IDLE pops at edge t+1. tx falls after edge t+2.
- Frame timing: one frame is 10*CLKS_PER_BIT cycles (11* with parity). Back-to-back frames have exactly one IDLE cycle between the stop bit and the next start bit.
- Baud counter counts 0..CLKS_PER_BIT-1. State and bit changes happen on terminal count only.
- busy = (state≠IDLE) | (count≠0).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = XOR of data[7:0] (even parity), held CLKS_PER_BIT cycles. The frame becomes 11 bits.
- Undefined: there is no PARITY state, and the frame is strict 8N1.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the UART_VALID_BIT=8 index;
  - the DATA_BITS=8 constant.
- One sub-module, sync_fifo (DATA_W=8, DEPTH), owns the storage, pointers and count. It exposes push, pop, wdata, rdata, full, empty and count. The FSM and overflow logic remain in uart_tx_fifo.

Test Plan:
- Single byte: CLKS_PER_BIT=4, push 0x55 once → tx reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop). Each bit lasts 4 cycles. The falling edge comes 2 cycles after the push. busy drops after the stop bit.
- Back-to-back: push 0x41 then 0x42 on consecutive cycles → two 40-cycle frames separated by exactly 1 idle-high cycle. fifo_count peaks at 1.
- Overflow: DEPTH=16, push 20 bytes 0x00..0x13 on consecutive cycles → fifo_full asserts and overflow=1. Received bytes are 0x00..0x10 (the first pops immediately, then 16 are buffered). The rest are dropped.
- Push on pop when full: fill to 16, then push 0xAA in the same cycle IDLE pops → accepted, count stays 16, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 of 0xF0 with 3 bytes queued → next cycle tx=1, busy=0, count=0. No further frames appear.
- Parity (UART_TX_PARITY_EN): push 0x07 → parity bit=1. Push 0x03 → parity bit=0. Each frame is 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared states and constants for the console UART transmitter
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int UART_VALID_BIT = 8;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-around pointers and a separate occupancy count
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    assign rdata = mem[rptr];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    // storage is not reset; only pointers and count define validity
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= wdata;
    end
    // pointers wrap naturally at DEPTH; count holds on simultaneous push and pop
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= (push && !pop) ? count + (AW+1)'(1) : (pop && !push) ? count - (AW+1)'(1) : count;
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers console strobes and serialises them as 8N1; define UART_TX_PARITY_EN for an even parity bit
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW = $clog2(FIFO_DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [8:0]         uart_in,
    output logic               tx,
    output logic               busy,
    output logic               fifo_full,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0] bit_idx, bit_n;
    logic [DATA_BITS-1:0] data_q, data_n, rdata;
    logic tx_n, tc, pop, push, empty;
    assign push = uart_in[UART_VALID_BIT] & (~fifo_full | pop);
    assign tc = baud == BW'(CLKS_PER_BIT - 1);
    assign busy = (state != IDLE) | (fifo_count != '0);
    sync_fifo #(.DATA_W(DATA_BITS), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wdata(uart_in[DATA_BITS-1:0]),
        .rdata(rdata),
        .full(fifo_full),
        .empty(empty),
        .count(fifo_count)
    );
    // state, counters and the registered line; tx lags the state by one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            baud <= '0;
            bit_idx <= '0;
            data_q <= '0;
            tx <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            baud <= baud_n;
            bit_idx <= bit_n;
            data_q <= data_n;
            tx <= tx_n;
            overflow <= overflow | (uart_in[UART_VALID_BIT] & fifo_full & ~pop);
        end
    end
    // next state, pop request and line level; transitions only on baud terminal count
    always_comb begin
        state_n = state;
        bit_n = bit_idx;
        data_n = data_q;
        pop = 1'b0;
        tx_n = 1'b1;
        baud_n = (state == IDLE || tc) ? '0 : baud + BW'(1);
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    data_n = rdata;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (tc) begin
                    state_n = DATA;
                    bit_n = '0;
                end
            end
            DATA: begin
                tx_n = data_q[bit_idx];
                if (tc) begin
`ifdef UART_TX_PARITY_EN
                    state_n = (bit_idx == 3'(DATA_BITS - 1)) ? PARITY : DATA;
`else
                    state_n = (bit_idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
`endif
                    bit_n = bit_idx + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_n = ^data_q;
                if (tc) state_n = STOP;
            end
`endif
            STOP: begin
                if (tc) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench with a line-decoding monitor and frame-level model
module tb_uart_tx_fifo;
    localparam int CPB = 4;
    localparam int DEPTH = 16;
    localparam int AW = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [8:0] uart_in = '0;
    logic tx, busy, fifo_full, overflow;
    logic [AW:0] fifo_count;

    int tests = 0;
    int fails = 0;
    int mon_err = 0;
    bit mon_ign = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit exp_wave[$];
    logic [7:0] mon_d;
    logic mon_v;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .uart_in(uart_in),
        .tx(tx),
        .busy(busy),
        .fifo_full(fifo_full),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Line monitor: decodes frames by mid-bit sampling, independent of DUT internals
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (tx === 1'b0) begin
                mon_d = '0;
                repeat (CPB / 2) @(posedge clock);
                #2;
                if (tx !== 1'b0 && !mon_ign) mon_err++;
                for (int k = 1; k < NB; k++) begin
                    repeat (CPB) @(posedge clock);
                    #2;
                    mon_v = tx;
                    if (k <= 8) mon_d[k-1] = mon_v;
                    else if (k == NB - 1) begin
                        if (mon_v !== 1'b1 && !mon_ign) mon_err++;
                    end else begin
                        if (mon_v !== ^mon_d && !mon_ign) mon_err++;
                    end
                end
                if (!mon_ign) rx_q.push_back(mon_d);
            end
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        uart_in = {1'b1, b};
        step();
        uart_in = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic bit frame_bit(input logic [7:0] b, input int k);
        return k == 0 ? 1'b0 : k <= 8 ? b[k-1] : k == NB - 1 ? 1'b1 : ^b;
    endfunction

    task automatic add_frame(input logic [7:0] b);
        for (int k = 0; k < NB; k++)
            for (int c = 0; c < CPB; c++) exp_wave.push_back(frame_bit(b, k));
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) exp_wave.push_back(1'b1);
    endtask

    task automatic run_wave(input string name, output int peak);
        int bad;
        logic got;
        bit want;
        bad = -1;
        got = 1'b1;
        want = 1'b1;
        peak = 0;
        for (int i = 0; i < exp_wave.size(); i++) begin
            step();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (tx !== exp_wave[i] && bad < 0) begin
                bad = i;
                got = tx;
                want = exp_wave[i];
            end
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: cycle %0d tx got %b, required %b", name, bad, got, want);
        end
        exp_wave.delete();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            step();
            n++;
        end
        repeat (FRAME) step();
        tests++;
        if (n >= 20000) begin
            fails++;
            $display("FAIL %s_drain: busy got %b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic compare_rx(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            if (rx_q[i] !== exp_q[i] && bad < 0) bad = i;
        tests++;
        if (rx_q.size() != exp_q.size() || bad >= 0) begin
            fails++;
            if (bad >= 0)
                $display("FAIL %s: byte %0d got %h, required %h (sizes %0d/%0d)", name, bad, rx_q[bad], exp_q[bad], rx_q.size(), exp_q.size());
            else
                $display("FAIL %s: received %0d bytes, required %0d", name, rx_q.size(), exp_q.size());
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        do_reset();
        tests += 5;
        if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b, required 1", tx); end
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b, required 0", fifo_full); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        if (fifo_count !== '0) begin fails++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    endtask

    task automatic test_single;
        int peak;
        push(8'h55);
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL single_early: tx got %b right after push, required 1", tx); end
        add_idle(1);
        add_frame(8'h55);
        add_idle(2);
        run_wave("single_wave", peak);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b after frame, required 0", busy); end
        exp_q.push_back(8'h55);
        repeat (4) step();
        compare_rx("single_rx");
    endtask

    task automatic test_back_to_back;
        int peak;
        push(8'h41);
        push(8'h42);
        add_frame(8'h41);
        add_idle(1);
        add_frame(8'h42);
        add_idle(2);
        run_wave("b2b_wave", peak);
        tests++;
        if (peak != 1) begin fails++; $display("FAIL b2b_peak: fifo_count peak got %0d, required 1", peak); end
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        wait_idle("b2b");
        compare_rx("b2b_rx");
    endtask

    task automatic test_overflow;
        int occ;
        bit pop_now;
        occ = 0;
        for (int i = 0; i < 20; i++) begin
            pop_now = (i == 1);
            if (occ < DEPTH || pop_now) begin
                exp_q.push_back(8'(i));
                occ++;
            end
            if (pop_now) occ--;
            push(8'(i));
        end
        tests += 3;
        if (fifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full: got %b, required 1", fifo_full); end
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
        if (int'(fifo_count) != occ) begin fails++; $display("FAIL ovf_count: got %0d, required %0d", fifo_count, occ); end
        wait_idle("ovf");
        compare_rx("ovf_rx");
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    endtask

    task automatic test_push_on_pop;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            push(8'(i + 8'h20));
            exp_q.push_back(8'(i + 8'h20));
        end
        repeat (FRAME - 15) step();
        tests += 2;
        if (fifo_full !== 1'b1) begin fails++; $display("FAIL pop_full: got %b, required 1", fifo_full); end
        if (fifo_count !== 5'd16) begin fails++; $display("FAIL pop_pre_count: got %0d, required 16", fifo_count); end
        push(8'hAA);
        exp_q.push_back(8'hAA);
        tests += 2;
        if (fifo_count !== 5'd16) begin fails++; $display("FAIL pop_count: got %0d, required 16", fifo_count); end
        if (overflow !== 1'b0) begin fails++; $display("FAIL pop_overflow: got %b, required 0", overflow); end
        wait_idle("pop");
        compare_rx("pop_rx");
    endtask

    task automatic test_reset_mid;
        bit quiet;
        mon_ign = 1'b1;
        push(8'hF0);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        repeat (15) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests += 4;
        if (tx !== 1'b1) begin fails++; $display("FAIL mid_tx: got %b, required 1", tx); end
        if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b, required 0", busy); end
        if (fifo_count !== '0) begin fails++; $display("FAIL mid_count: got %0d, required 0", fifo_count); end
        if (fifo_full !== 1'b0) begin fails++; $display("FAIL mid_full: got %b, required 0", fifo_full); end
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        tests++;
        if (!quiet) begin fails++; $display("FAIL mid_quiet: line activity got after reset, required none"); end
        mon_ign = 1'b0;
        rx_q.delete();
    endtask

    task automatic test_random;
        logic [7:0] b;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push(b);
            repeat ($urandom_range(0, 60)) step();
        end
        wait_idle("rand");
        compare_rx("rand_rx");
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL rand_overflow: got %b, required 0", overflow); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        int peak;
        push(8'h07);
        repeat (9 * CPB + 3) step();
        tests++;
        if (tx !== 1'b1) begin fails++; $display("FAIL parity_07: got %b, required 1", tx); end
        wait_idle("par1");
        push(8'h03);
        add_idle(1);
        add_frame(8'h03);
        add_idle(2);
        run_wave("parity_03_wave", peak);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        wait_idle("par2");
        compare_rx("parity_rx");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_on_pop();
        test_reset_mid();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        tests++;
        if (mon_err != 0) begin fails++; $display("FAIL framing: monitor errors got %0d, required 0", mon_err); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
